cpu_trace_buffer: RTL and testbench

- Hardware successor to the CPU bench's per-cycle print monitor.
- Records register-file writeback events from the pipelined CPU into a parametrised circular buffer.
- Stops a programmable number of events after a PC-match trigger, then drains the captured history oldest-first over a valid/ready port.
- Sits beside the CPU top; taps the fetch PC and the register-file write port.

---
 rtl/cpu_trace_pkg.sv | 17 +
 rtl/trace_ram.sv | 25 ++
 rtl/cpu_trace_buffer.sv | 163 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU writeback trace buffer.
// The record width grows by TS_W when TRACE_TIMESTAMP_EN is defined.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  function automatic int trace_rec_w(input int pc_w, input int data_w, input int ra_w,
                                     input int ts_w, input bit ts_en);
    return 1 + ra_w + data_w + pc_w + (ts_en ? ts_w : 0);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x REC_W trace storage: synchronous write, asynchronous read.
module trace_ram #(
  parameter int DEPTH = 8,
  parameter int REC_W = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [REC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [REC_W-1:0] rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale contents are never presented and a reset would only cost area.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace of register-file writebacks: captures until a PC trigger plus
// post_cnt events, then drains oldest-first. Optional macro: TRACE_TIMESTAMP_EN.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int TS_W   = 16,
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1,
`else
  localparam bit TS_EN = 1'b0,
`endif
  localparam int REC_W = trace_rec_w(PC_W, DATA_W, RA_W, TS_W, TS_EN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [CNT_W-1:0]  post_cnt,
  input  logic              ev_valid,
  input  logic [PC_W-1:0]   ev_pc,
  input  logic              ev_rf_we,
  input  logic [RA_W-1:0]   ev_rf_addr,
  input  logic [DATA_W-1:0] ev_rf_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [REC_W-1:0]  rd_data,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic              wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST_C = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  trace_state_e     state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             wrapped_q, wrapped_d;

  logic             capture;
  logic             pop;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] ram_rdata;

`ifdef TRACE_TIMESTAMP_EN
  // Free-running cycle stamp; only reset clears it so stamps stay comparable across arms.
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign wr_rec = {ts_q, ev_rf_we, ev_rf_addr, ev_rf_data, ev_pc};
`else
  assign wr_rec = {ev_rf_we, ev_rf_addr, ev_rf_data, ev_pc};
`endif

  assign capture  = !arm && ev_valid && (state_q == ARMED || state_q == POST);
  assign rd_valid = (state_q == DONE) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;

    if (arm) begin
      state_d   = ARMED;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rem_d     = '0;
      wrapped_d = 1'b0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (capture) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL_C) begin
              rd_ptr_d  = rd_ptr_q + 1'b1;
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end

            if (state_q == ARMED) begin
              if (ev_pc == trig_pc) begin
                rem_d   = (post_cnt > MAX_POST_C) ? MAX_POST_C : post_cnt;
                state_d = (rem_d == '0) ? DONE : POST;
              end
            end else begin
              rem_d = rem_q - 1'b1;
              if (rem_q == ONE_C) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == ONE_C) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      wrapped_q <= wrapped_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Gated so the port reads zero whenever nothing is offered.
  assign rd_data = rd_valid ? ram_rdata : '0;
  assign state   = state_q;
  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus random
// rounds, compared against a queue-based reference model of the trace history.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  localparam int PC_W   = 8;
  localparam int DATA_W = 8;
  localparam int RA_W   = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int REC_W  = trace_rec_w(PC_W, DATA_W, RA_W, TS_W, TS_EN);
  localparam int BASE_W = 1 + RA_W + DATA_W + PC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0;
  logic [PC_W-1:0]   trig_pc = '0;
  logic [CNT_W-1:0]  post_cnt = '0;
  logic              ev_valid = 1'b0;
  logic [PC_W-1:0]   ev_pc = '0;
  logic              ev_rf_we = 1'b0;
  logic [RA_W-1:0]   ev_rf_addr = '0;
  logic [DATA_W-1:0] ev_rf_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [REC_W-1:0]  rd_data;
  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              wrapped;

  cpu_trace_buffer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_pc    (trig_pc),
    .post_cnt   (post_cnt),
    .ev_valid   (ev_valid),
    .ev_pc      (ev_pc),
    .ev_rf_we   (ev_rf_we),
    .ev_rf_addr (ev_rf_addr),
    .ev_rf_data (ev_rf_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .state      (state),
    .count      (count),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the captured history as a queue, oldest at the front.
  logic [BASE_W-1:0] m_q[$];
  int                m_st  = 0;   // 0 idle, 1 armed, 2 post-trigger, 3 done
  int                m_rem = 0;
  bit                m_wr  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [BASE_W-1:0] dropped;
    if (!reset) begin
      m_q.delete(); m_st = 0; m_rem = 0; m_wr = 1'b0;
    end else if (arm) begin
      m_q.delete(); m_st = 1; m_rem = 0; m_wr = 1'b0;
    end else if ((m_st == 1 || m_st == 2) && ev_valid) begin
      m_q.push_back({ev_rf_we, ev_rf_addr, ev_rf_data, ev_pc});
      if (m_q.size() > DEPTH) begin
        dropped = m_q.pop_front();
        m_wr = 1'b1;
      end
      if (m_st == 1) begin
        if (ev_pc == trig_pc) begin
          m_rem = (int'(post_cnt) > DEPTH - 1) ? DEPTH - 1 : int'(post_cnt);
          m_st  = (m_rem == 0) ? 3 : 2;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_st = 3;
      end
    end else if (m_st == 3 && m_q.size() > 0 && rd_ready) begin
      dropped = m_q.pop_front();
      if (m_q.size() == 0) m_st = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    bit exp_valid;
    exp_valid = (m_st == 3) && (m_q.size() != 0);
    check({tag, ".state"},    64'(state),    64'(m_st));
    check({tag, ".count"},    64'(count),    64'(m_q.size()));
    check({tag, ".wrapped"},  64'(wrapped),  64'(m_wr));
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(exp_valid));
    if (exp_valid) check({tag, ".rd_data"}, 64'(rd_data[BASE_W-1:0]), 64'(m_q[0]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drive_ev(input bit valid, input logic [PC_W-1:0] pc);
    ev_valid   = valid;
    ev_pc      = pc;
    ev_rf_we   = 1'($urandom);
    ev_rf_addr = RA_W'($urandom);
    ev_rf_data = DATA_W'($urandom);
  endtask

  task automatic ev(input string tag, input bit valid, input logic [PC_W-1:0] pc);
    drive_ev(valid, pc);
    tick(tag);
    ev_valid = 1'b0;
  endtask

  // The arm cycle carries a valid event whose PC equals the trigger; it must be ignored.
  task automatic do_arm(input string tag, input logic [PC_W-1:0] tpc, input logic [CNT_W-1:0] pcnt);
    arm      = 1'b1;
    trig_pc  = tpc;
    post_cnt = pcnt;
    drive_ev(1'b1, tpc);
    tick(tag);
    arm      = 1'b0;
    ev_valid = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input int first_pc, input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, ".pc"}, 64'(rd_data[PC_W-1:0]), 64'(first_pc + i));
      tick(tag);
    end
    rd_ready = 1'b0;
    check({tag, ".idle"}, 64'(state), 64'(IDLE));
  endtask

  logic [REC_W-1:0] held;

  initial begin
    // Reset state
    @(negedge clk);
    tick("rst");
    tick("rst");
    check("rst.rd_data", 64'(rd_data), 64'd0);
    check("rst.state_c", 64'(state), 64'(IDLE));
    reset = 1'b1;
    tick("idle");

    // Basic: trigger at PC 3, two post events; invalid cycle carrying PC 3 in between
    do_arm("t1.arm", 8'd3, 4'd2);
    check("t1.armed", 64'(state), 64'(ARMED));
    ev("t1", 1'b1, 8'd1);
    ev("t1.gap", 1'b0, 8'd3);
    ev("t1", 1'b1, 8'd2);
    ev("t1", 1'b1, 8'd3);
    ev("t1", 1'b1, 8'd4);
    ev("t1.gap", 1'b0, 8'd9);
    ev("t1", 1'b1, 8'd5);
    check("t1.done", 64'(state), 64'(DONE));
    check("t1.count", 64'(count), 64'd5);
    check("t1.wrapped", 64'(wrapped), 64'd0);
    drain_expect("t1.drain", 1, 5);

    // Wrap: 23 events into 8 entries
    do_arm("t2.arm", 8'd20, 4'd3);
    for (int p = 1; p <= 23; p++) ev("t2", 1'b1, PC_W'(p));
    check("t2.done", 64'(state), 64'(DONE));
    check("t2.count", 64'(count), 64'd8);
    check("t2.wrapped", 64'(wrapped), 64'd1);
    drain_expect("t2.drain", 16, 8);

    // Backpressure, then reset mid-drain
    do_arm("t3.arm", 8'd2, 4'd3);
    for (int p = 1; p <= 5; p++) ev("t3", 1'b1, PC_W'(p));
    check("t3.done", 64'(state), 64'(DONE));
    held = rd_data;
    for (int i = 0; i < 4; i++) begin
      tick("t3.hold");
      check("t3.hold_data", 64'(rd_data), 64'(held));
      check("t3.hold_count", 64'(count), 64'd5);
    end
    rd_ready = 1'b1;
    tick("t3.pop");
    rd_ready = 1'b0;
    check("t3.pop_count", 64'(count), 64'd4);
    check("t3.pop_pc", 64'(rd_data[PC_W-1:0]), 64'd2);
    rd_ready = 1'b1;
    reset = 1'b0;
    tick("t3.rst");
    check("t3.rst_state", 64'(state), 64'(IDLE));
    check("t3.rst_valid", 64'(rd_valid), 64'd0);
    reset = 1'b1;
    rd_ready = 1'b0;
    tick("t3.post");

    // post_cnt = 0 with the first event triggering
    do_arm("t4.arm", 8'd9, 4'd0);
    ev("t4", 1'b1, 8'd9);
    check("t4.done", 64'(state), 64'(DONE));
    check("t4.count", 64'(count), 64'd1);
    drain_expect("t4.drain", 9, 1);

    // post_cnt = 15 clamps to DEPTH-1
    do_arm("t5.arm", 8'd1, 4'd15);
    for (int p = 1; p <= 7; p++) ev("t5", 1'b1, PC_W'(p));
    check("t5.post", 64'(state), 64'(POST));
    ev("t5", 1'b1, 8'd8);
    check("t5.done", 64'(state), 64'(DONE));
    check("t5.count", 64'(count), 64'd8);
    check("t5.wrapped", 64'(wrapped), 64'd0);
    drain_expect("t5.drain", 1, 8);

    // arm during POST discards history
    do_arm("t6.arm", 8'd1, 4'd5);
    ev("t6", 1'b1, 8'd1);
    ev("t6", 1'b1, 8'd2);
    check("t6.post", 64'(state), 64'(POST));
    do_arm("t6.rearm", 8'd4, 4'd1);
    check("t6.armed", 64'(state), 64'(ARMED));
    check("t6.count", 64'(count), 64'd0);
    check("t6.valid", 64'(rd_valid), 64'd0);

    // Random rounds against the model
    for (int r = 0; r < 12; r++) begin
      do_arm("rnd.arm", PC_W'($urandom_range(0, 7)), CNT_W'($urandom_range(0, 15)));
      for (int c = 0; c < 30; c++) begin
        drive_ev($urandom_range(0, 2) != 0, PC_W'($urandom_range(0, 7)));
        rd_ready = 1'($urandom);
        tick("rnd.cap");
      end
      for (int c = 0; c < 60 && m_st != 0 && m_st != 1; c++) begin
        drive_ev(1'($urandom), PC_W'($urandom_range(0, 7)));
        rd_ready = 1'($urandom);
        tick("rnd.drain");
      end
      ev_valid = 1'b0;
      rd_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
